// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - per-button synchroniser, 4-state debounce FSM and typematic auto-repeat
// Raw active-low pins in; clean level, press/release pulses and repeat pulses out.
module button_debounce #(
  parameter int BUTTONS         = 5,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int REPEAT_DELAY    = 13500000,
  parameter int REPEAT_PERIOD   = 2700000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BUTTONS-1:0] button_n,
  output logic [BUTTONS-1:0] pressed,
  output logic [BUTTONS-1:0] press_pulse,
  output logic [BUTTONS-1:0] release_pulse,
  output logic [BUTTONS-1:0] repeat_pulse
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RP_LAST = RW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam bit            REPEAT_EN = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;

  logic [BUTTONS-1:0] sync1, sync2, s;

  // Sync flops reset to the released level so a held button re-debounces after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= button_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  for (genvar g = 0; g < BUTTONS; g++) begin : g_chan
    state_t        state;
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rp_cnt;
    logic          first_done;
    logic          pressed_r, press_r, release_r, repeat_r;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state      <= IDLE;
        db_cnt     <= '0;
        rp_cnt     <= '0;
        first_done <= 1'b0;
        pressed_r  <= 1'b0;
        press_r    <= 1'b0;
        release_r  <= 1'b0;
        repeat_r   <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        repeat_r  <= 1'b0;
        case (state)
          IDLE: begin
            if (s[g]) begin
              state  <= PRESS_CHK;
              db_cnt <= '0;
            end
          end
          PRESS_CHK: begin
            if (!s[g]) begin
              state <= IDLE;
            end else if (db_cnt == DB_LAST) begin
              state      <= PRESSED;
              pressed_r  <= 1'b1;
              press_r    <= 1'b1;
              rp_cnt     <= '0;
              first_done <= 1'b0;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          PRESSED: begin
            if (!s[g]) begin
              state  <= RELEASE_CHK;
              db_cnt <= '0;
            end
            // Repeat timing only advances while PRESSED, so release bounces pause it.
            if (REPEAT_EN) begin
              if (!first_done && rp_cnt == RD_LAST) begin
                repeat_r   <= 1'b1;
                rp_cnt     <= '0;
                first_done <= 1'b1;
              end else if (first_done && rp_cnt == RP_LAST) begin
                repeat_r <= 1'b1;
                rp_cnt   <= '0;
              end else begin
                rp_cnt <= rp_cnt + 1'b1;
              end
            end
          end
          RELEASE_CHK: begin
            if (s[g]) begin
              state <= PRESSED;
            end else if (db_cnt == DB_LAST) begin
              state     <= IDLE;
              pressed_r <= 1'b0;
              release_r <= 1'b1;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign pressed[g]       = pressed_r;
    assign press_pulse[g]   = press_r;
    assign release_pulse[g] = release_r;
    assign repeat_pulse[g]  = repeat_r;
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - scoreboard bench for button_debounce
// Stimulus pushes expected pulse events; a monitor pops and checks each pulse cycle.
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] button_n;
  logic [4:0] pressed, press_pulse, release_pulse, repeat_pulse;

  typedef struct {
    int         at;
    logic [4:0] pp;
    logic [4:0] rl;
    logic [4:0] rp;
    logic [4:0] lv;
  } ev_t;

  ev_t q[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  button_debounce #(
    .BUTTONS(5), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .reset(reset), .button_n(button_n), .pressed(pressed),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic push(input int at, input logic [4:0] pp, input logic [4:0] rl,
                      input logic [4:0] rp, input logic [4:0] lv);
    ev_t e;
    e.at = at; e.pp = pp; e.rl = rl; e.rp = rp; e.lv = lv;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: cycle count advances at each rising edge, outputs sampled 2 ns later.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if ((press_pulse | release_pulse | repeat_pulse) != 5'b0) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: cycle %0d press=%b rel=%b rep=%b, want none",
                   cyc, press_pulse, release_pulse, repeat_pulse);
        end else begin
          e = q.pop_front();
          if (e.at != cyc || e.pp !== press_pulse || e.rl !== release_pulse ||
              e.rp !== repeat_pulse || e.lv !== pressed) begin
            bad++;
            $display("FAIL pulse_event: got cyc=%0d press=%b rel=%b rep=%b lvl=%b want cyc=%0d press=%b rel=%b rep=%b lvl=%b",
                     cyc, press_pulse, release_pulse, repeat_pulse, pressed,
                     e.at, e.pp, e.rl, e.rp, e.lv);
          end
        end
      end
    end
  end

  initial begin
    int c;
    int r;
    reset    = 1'b1;
    button_n = 5'b11111;
    repeat (2) @(negedge clk);
    chk("rst_pressed", pressed, 5'b0);
    chk("rst_press_pulse", press_pulse, 5'b0);
    chk("rst_release_pulse", release_pulse, 5'b0);
    chk("rst_repeat_pulse", repeat_pulse, 5'b0);
    reset = 1'b0;
    wait_to(cyc + 3);

    // Clean press and release on channel 0
    c = cyc;
    button_n[0] = 1'b0;
    push(c + 7, 5'b00001, 5'b0, 5'b0, 5'b00001);
    wait_to(c + 8);
    chk("t1_pulse_one_cycle", press_pulse, 5'b0);
    chk("t1_level", pressed, 5'b00001);
    button_n[0] = 1'b1;
    push(c + 15, 5'b0, 5'b00001, 5'b0, 5'b0);
    wait_to(c + 25);

    // 3-cycle low glitch on channel 1 must be rejected
    c = cyc;
    button_n[1] = 1'b0;
    wait_to(c + 3);
    button_n[1] = 1'b1;
    wait_to(c + 12);
    chk("t2_bounce_level", pressed, 5'b0);

    // Held channel 1 with 3-cycle high glitch: no release
    c = cyc;
    button_n[1] = 1'b0;
    push(c + 7, 5'b00010, 5'b0, 5'b0, 5'b00010);
    wait_to(c + 9);
    button_n[1] = 1'b1;
    wait_to(c + 12);
    button_n[1] = 1'b0;
    wait_to(c + 16);
    chk("t2_glitch_level", pressed, 5'b00010);
    button_n[1] = 1'b1;
    push(c + 23, 5'b0, 5'b00010, 5'b0, 5'b0);
    wait_to(c + 30);

    // Release latency on channel 2
    c = cyc;
    button_n[2] = 1'b0;
    push(c + 7, 5'b00100, 5'b0, 5'b0, 5'b00100);
    wait_to(c + 9);
    button_n[2] = 1'b1;
    push(c + 16, 5'b0, 5'b00100, 5'b0, 5'b0);
    wait_to(c + 15);
    chk("t3_level_before_release", pressed, 5'b00100);
    wait_to(c + 30);

    // Auto-repeat on channel 3: first after 10, then every 3
    c = cyc;
    button_n[3] = 1'b0;
    push(c + 7,  5'b01000, 5'b0, 5'b0,     5'b01000);
    push(c + 17, 5'b0,     5'b0, 5'b01000, 5'b01000);
    push(c + 20, 5'b0,     5'b0, 5'b01000, 5'b01000);
    push(c + 23, 5'b0,     5'b0, 5'b01000, 5'b01000);
    push(c + 26, 5'b0,     5'b0, 5'b01000, 5'b01000);
    wait_to(c + 24);
    button_n[3] = 1'b1;
    push(c + 31, 5'b0, 5'b01000, 5'b0, 5'b0);
    wait_to(c + 45);
    chk("t4_level_after_release", pressed, 5'b0);

    // Simultaneous press on channels 4 and 0
    c = cyc;
    button_n = 5'b01110;
    push(c + 7, 5'b10001, 5'b0, 5'b0, 5'b10001);
    wait_to(c + 9);
    button_n = 5'b11111;
    push(c + 16, 5'b0, 5'b10001, 5'b0, 5'b0);
    wait_to(c + 30);

    // Reset while channel 0 is pressed, button still held afterwards
    c = cyc;
    button_n[0] = 1'b0;
    push(c + 7, 5'b00001, 5'b0, 5'b0, 5'b00001);
    wait_to(c + 9);
    chk("t6_level_before_reset", pressed, 5'b00001);
    reset = 1'b1;
    #1;
    chk("t6_rst_pressed", pressed, 5'b0);
    chk("t6_rst_press_pulse", press_pulse, 5'b0);
    chk("t6_rst_release_pulse", release_pulse, 5'b0);
    chk("t6_rst_repeat_pulse", repeat_pulse, 5'b0);
    wait_to(c + 11);
    reset = 1'b0;
    r = cyc;
    push(r + 7, 5'b00001, 5'b0, 5'b0, 5'b00001);
    wait_to(r + 9);
    button_n[0] = 1'b1;
    push(r + 16, 5'b0, 5'b00001, 5'b0, 5'b0);

    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    while (q.size() != 0) begin
      ev_t e;
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event: got nothing want cyc=%0d press=%b rel=%b rep=%b",
               e.at, e.pp, e.rl, e.rp);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
